// File: rtl/lane_merge.sv
// lane_merge: merges two valid/ready lanes through per-lane FIFOs into one round-robin, lane-tagged registered output (clk, async active-low rst; laneN_data/valid/ready in, data_out/out_valid/out_lane/out_ready out)
module lane_merge #(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] lane1_data,
  input  logic                  lane1_valid,
  output logic                  lane1_ready,
  input  logic [DATA_WIDTH-1:0] lane2_data,
  input  logic                  lane2_valid,
  output logic                  lane2_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_lane
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_WIDTH-1:0] din [2];
  logic [DATA_WIDTH-1:0] head [2];
  logic [1:0] vin, rdy, push, pop, ne;
  logic live, last_grant, grant, load;
  assign din[0] = lane1_data;
  assign din[1] = lane2_data;
  assign vin = {lane2_valid, lane1_valid};
  assign lane1_ready = rdy[0];
  assign lane2_ready = rdy[1];
  assign grant = &ne ? ~last_grant : ne[1];
  assign load = !out_valid || out_ready;
  assign pop = {load && |ne && grant, load && |ne && !grant};
  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    assign rdy[l] = live && cnt != CW'(DEPTH);
    assign push[l] = vin[l] && rdy[l];
    assign ne[l] = cnt != '0;
    assign head[l] = mem[rp];
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (push[l]) wp <= wp + 1'b1;
        if (pop[l]) rp <= rp + 1'b1;
        cnt <= cnt + CW'(push[l]) - CW'(pop[l]);
      end
    always_ff @(posedge clk)
      if (push[l]) mem[wp] <= din[l];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      data_out <= '0;
      out_lane <= 1'b0;
      last_grant <= 1'b1;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      if (load) begin
        out_valid <= |ne;
        if (|ne) begin
          data_out <= head[grant];
          out_lane <= grant;
          last_grant <= grant;
        end
      end
    end
endmodule

// File: tb/tb_lane_merge.sv
// tb_lane_merge: randomized and directed scoreboard bench for lane_merge against a queue-based reference model
module tb_lane_merge;
  localparam int DW = 3;
  localparam int DEPTH = 2;
  logic clk = 0;
  logic rst = 1;
  logic [DW-1:0] lane1_data = '0, lane2_data = '0, data_out;
  logic lane1_valid = 0, lane2_valid = 0, lane1_ready, lane2_ready;
  logic out_valid, out_ready = 0, out_lane;
  int n_chk = 0, n_fail = 0;
  bit rnd = 0;
  logic [DW-1:0] src1 [$], src2 [$], m1 [$], m2 [$];
  logic [DW:0] exp_q [$], got [$], sent [$];
  bit mov = 0, lg = 1, live_m = 0;
  lane_merge #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .lane1_data(lane1_data), .lane1_valid(lane1_valid), .lane1_ready(lane1_ready),
    .lane2_data(lane2_data), .lane2_valid(lane2_valid), .lane2_ready(lane2_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      m1.delete();
      m2.delete();
      exp_q.delete();
      mov = 0;
      lg = 1;
      live_m = 0;
      chk("reset_ready1", int'(lane1_ready), 0);
      chk("reset_ready2", int'(lane2_ready), 0);
      chk("reset_out_valid", int'(out_valid), 0);
    end else begin
      bit p1, p2, g;
      logic [DW-1:0] w;
      chk("lane1_ready", int'(lane1_ready), int'(live_m && m1.size() < DEPTH));
      chk("lane2_ready", int'(lane2_ready), int'(live_m && m2.size() < DEPTH));
      chk("out_valid", int'(out_valid), int'(mov));
      p1 = lane1_valid && live_m && m1.size() < DEPTH;
      p2 = lane2_valid && live_m && m2.size() < DEPTH;
      if (!mov || out_ready) begin
        if (m1.size() > 0 || m2.size() > 0) begin
          g = (m1.size() > 0 && m2.size() > 0) ? !lg : (m2.size() > 0);
          w = g ? m2.pop_front() : m1.pop_front();
          exp_q.push_back({g, w});
          mov = 1;
          lg = g;
        end else mov = 0;
      end
      if (p1) m1.push_back(lane1_data);
      if (p2) m2.push_back(lane2_data);
      live_m = 1;
    end
  end
  always begin
    @(negedge clk);
    #1;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("scoreboard_empty_on_output", 1, 0);
      else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        chk("sb_data", int'(data_out), int'(e[DW-1:0]));
        chk("sb_lane", int'(out_lane), int'(e[DW]));
      end
      got.push_back({out_lane, data_out});
    end
  end
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      bit a1, a2;
      @(negedge clk);
      lane1_valid = src1.size() > 0 && (!rnd || $urandom_range(1) == 1);
      lane2_valid = src2.size() > 0 && (!rnd || $urandom_range(1) == 1);
      lane1_data = src1.size() > 0 ? src1[0] : DW'($urandom);
      lane2_data = src2.size() > 0 ? src2[0] : DW'($urandom);
      if (rnd) out_ready = $urandom_range(1) == 1;
      #1;
      a1 = lane1_valid && lane1_ready;
      a2 = lane2_valid && lane2_ready;
      @(posedge clk);
      if (a1) void'(src1.pop_front());
      if (a2) void'(src2.pop_front());
      #1;
    end
  endtask
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 0;
    src1.delete();
    src2.delete();
    lane1_valid = 0;
    lane2_valid = 0;
    repeat (n) @(negedge clk);
    got.delete();
    rst = 1;
  endtask
  initial begin
    int e2 [8] = '{1, 5, 2, 6, 3, 7, 4, 0};
    #1 rst = 0;
    do_reset(3);
    out_ready = 1;
    src1.push_back(3'b101);
    run(4);
    chk("t1_count", got.size(), 1);
    if (got.size() > 0) chk("t1_word", int'(got[0]), int'({1'b0, 3'b101}));
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      src1.push_back(DW'(i + 1));
      src2.push_back(DW'(i + 5));
    end
    run(12);
    chk("t2_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("t2_word%0d", i), int'(got[i]), (i % 2) * 8 + e2[i]);
    got.delete();
    out_ready = 0;
    for (int i = 0; i < 5; i++) src1.push_back(DW'(i + 1));
    run(6);
    chk("t3_ready_low", int'(lane1_ready), 0);
    chk("t3_accepted", 5 - src1.size(), 3);
    chk("t3_hold_data", int'(data_out), 1);
    out_ready = 1;
    run(10);
    chk("t3_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk($sformatf("t3_word%0d", i), int'(got[i]), i + 1);
    got.delete();
    out_ready = 0;
    src2 = '{3'd2, 3'd4, 3'd6, 3'd1};
    run(5);
    chk("t4_full_ready", int'(lane2_ready), 0);
    chk("t4_pending", src2.size(), 1);
    out_ready = 1;
    run(1);
    chk("t4_no_push_on_pop", src2.size(), 1);
    out_ready = 0;
    run(1);
    chk("t4_push_next_edge", src2.size(), 0);
    out_ready = 1;
    run(8);
    chk("t4_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("t4_word%0d", i), int'(got[i]), 8 + (i == 3 ? 1 : 2 * i + 2));
    got.delete();
    out_ready = 0;
    src1 = '{3'd3, 3'd4, 3'd5};
    src2 = '{3'd6, 3'd7, 3'd1};
    run(4);
    chk("t5_valid_before", int'(out_valid), 1);
    #1 rst = 0;
    #1;
    chk("t5_async_valid", int'(out_valid), 0);
    chk("t5_async_data", int'(data_out), 0);
    chk("t5_async_lane", int'(out_lane), 0);
    chk("t5_async_ready1", int'(lane1_ready), 0);
    src1.delete();
    src2.delete();
    lane1_valid = 0;
    lane2_valid = 0;
    repeat (2) @(negedge clk);
    got.delete();
    rst = 1;
    out_ready = 1;
    src1.push_back(3'd6);
    src2.push_back(3'd7);
    run(6);
    chk("t5_count", got.size(), 2);
    if (got.size() > 1) begin
      chk("t5_first", int'(got[0]), 6);
      chk("t5_second", int'(got[1]), 8 + 7);
    end
    got.delete();
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] w;
      w = DW'($urandom);
      if (i % 2 == 0) src1.push_back(w);
      else src2.push_back(w);
      sent.push_back({1'(i % 2), w});
      run(1);
    end
    run(4);
    chk("t6_count", got.size(), 20);
    for (int i = 0; i < 20 && i < got.size(); i++) chk($sformatf("t6_word%0d", i), int'(got[i]), int'(sent[i]));
    rnd = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) != 0 && src1.size() < 4) src1.push_back(DW'($urandom));
      if ($urandom_range(2) != 0 && src2.size() < 4) src2.push_back(DW'($urandom));
      run(1);
    end
    rnd = 0;
    out_ready = 1;
    run(20);
    chk("drain_src1", src1.size(), 0);
    chk("drain_src2", src2.size(), 0);
    chk("drain_scoreboard", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
